// File: rtl/ex_stage.sv
// Decode-and-execute slice: main decoder, ALU-control decoder and 32-bit ALU
// feeding an EX/MEM-style output register with asynchronous reset and flush.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] store_data,
  output logic [4:0]  wrreg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;
  logic        unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  // The rs index is consumed by the ID stage; only its data arrives here.
  assign unused_rs = ^instr[25:21];

  logic       regdst, alusrc;
  logic [1:0] aluop;
  logic       dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg;
  logic       dec_branch_eq, dec_branch_ne, dec_jump;

  always_comb begin
    regdst        = 1'b0;
    alusrc        = 1'b0;
    aluop         = 2'b00;
    dec_regwrite  = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_branch_eq = 1'b0;
    dec_branch_ne = 1'b0;
    dec_jump      = 1'b0;
    case (opcode)
      6'b000000: begin
        regdst       = 1'b1;
        dec_regwrite = 1'b1;
        aluop        = 2'b10;
      end
      6'b100011: begin
        alusrc       = 1'b1;
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_regwrite = 1'b1;
      end
      6'b101011: begin
        alusrc       = 1'b1;
        dec_memwrite = 1'b1;
      end
      6'b001000: begin
        alusrc       = 1'b1;
        dec_regwrite = 1'b1;
      end
      6'b000100: begin
        dec_branch_eq = 1'b1;
        aluop         = 2'b01;
      end
      6'b000101: begin
        dec_branch_ne = 1'b1;
        aluop         = 2'b01;
      end
      6'b000010: dec_jump = 1'b1;
      default: ;
    endcase
  end

  logic [3:0] aluctl;

  always_comb begin
    aluctl = 4'b0010;
    case (aluop)
      2'b01: aluctl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: aluctl = 4'b0010;
          6'b100010: aluctl = 4'b0110;
          6'b100100: aluctl = 4'b0000;
          6'b100101: aluctl = 4'b0001;
          6'b100110: aluctl = 4'b1101;
          6'b100111: aluctl = 4'b1100;
          6'b101010: aluctl = 4'b0111;
          default:   aluctl = 4'b1111;
        endcase
      end
      default: aluctl = 4'b0010;
    endcase
  end

  logic [31:0] op_b;
  logic [31:0] result;

  assign op_b = alusrc ? imm_sext : rt_data;

  always_comb begin
    result = 32'd0;
    case (aluctl)
      4'b0010: result = rs_data + op_b;
      4'b0110: result = rs_data - op_b;
      4'b0000: result = rs_data & op_b;
      4'b0001: result = rs_data | op_b;
      4'b1101: result = rs_data ^ op_b;
      4'b1100: result = ~(rs_data | op_b);
      4'b0111: result = {31'd0, $signed(rs_data) < $signed(op_b)};
      default: result = 32'd0;
    endcase
  end

  // Flush loads a bubble so the following stages see no side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      alu_out    <= 32'd0;
      zero       <= 1'b0;
      store_data <= 32'd0;
      wrreg      <= 5'd0;
      regwrite   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      branch_eq  <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
    end else begin
      alu_out    <= result;
      zero       <= (result == 32'd0);
      store_data <= rt_data;
      wrreg      <= regdst ? rd : rt;
      regwrite   <= dec_regwrite;
      memread    <= dec_memread;
      memwrite   <= dec_memwrite;
      memtoreg   <= dec_memtoreg;
      branch_eq  <= dec_branch_eq;
      branch_ne  <= dec_branch_ne;
      jump       <= dec_jump;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases plus randomized instructions
// checked against an instruction-level reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] alu_out, store_data;
  logic [4:0]  wrreg;
  logic        zero, regwrite, memread, memwrite, memtoreg, branch_eq, branch_ne, jump;

  ex_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .alu_out   (alu_out),
    .zero      (zero),
    .store_data(store_data),
    .wrreg     (wrreg),
    .regwrite  (regwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .jump      (jump)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  wrreg;
    logic        regwrite, memread, memwrite, memtoreg, beq, bne, jump;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } entry_t;

  entry_t scoreboard[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic exp_t actual();
    exp_t a;
    a = '{alu_out, zero, store_data, wrreg, regwrite, memread, memwrite, memtoreg,
          branch_eq, branch_ne, jump};
    return a;
  endfunction

  // Instruction-level semantics: what each MIPS instruction should produce.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [31:0] simm;
    e     = '0;
    simm  = {{16{i[15]}}, i[15:0]};
    e.wrreg = i[20:16];
    case (i[31:26])
      6'h00: begin
        e.regwrite = 1'b1;
        e.wrreg    = i[15:11];
        case (i[5:0])
          6'h20:   e.alu = a + b;
          6'h22:   e.alu = a - b;
          6'h24:   e.alu = a & b;
          6'h25:   e.alu = a | b;
          6'h26:   e.alu = a ^ b;
          6'h27:   e.alu = ~(a | b);
          6'h2a:   e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.alu = 32'd0;
        endcase
      end
      6'h23: begin e.alu = a + simm; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      6'h2b: begin e.alu = a + simm; e.memwrite = 1'b1; end
      6'h08: begin e.alu = a + simm; e.regwrite = 1'b1; end
      6'h04: begin e.alu = a - b; e.beq = 1'b1; end
      6'h05: begin e.alu = a - b; e.bne = 1'b1; end
      6'h02: begin e.alu = a + b; e.jump = 1'b1; end
      default: e.alu = a + b;
    endcase
    e.zero  = (e.alu == 32'd0);
    e.store = b;
    return e;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got alu=%h z=%b st=%h wr=%0d ctl=%b%b%b%b%b%b%b, want alu=%h z=%b st=%h wr=%0d ctl=%b%b%b%b%b%b%b",
               name, act.alu, act.zero, act.store, act.wrreg, act.regwrite, act.memread,
               act.memwrite, act.memtoreg, act.beq, act.bne, act.jump,
               exp.alu, exp.zero, exp.store, exp.wrreg, exp.regwrite, exp.memread,
               exp.memwrite, exp.memtoreg, exp.beq, exp.bne, exp.jump);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue what the next edge must show.
  task automatic drive(input string name, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic r);
    entry_t ent;
    @(posedge clk);
    #2;
    instr   = i;
    rs_data = a;
    rt_data = b;
    flush   = fl;
    rst     = r;
    ent.e    = (fl || r) ? '0 : model(i, a, b);
    ent.name = name;
    scoreboard.push_back(ent);
  endtask

  initial begin : monitor
    entry_t ent;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        ent = scoreboard.pop_front();
        check(ent.name, ent.e);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  initial begin : stimulus
    logic [5:0]  ops[8];
    logic [5:0]  functs[9];
    logic [31:0] i, a, b;
    ops    = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3f};
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h01};

    #3;
    check("reset_state", '0);
    drive("reset_held", 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b1);

    drive("add", 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);
    drive("lw_neg_imm", 32'h8C41_FFFC, 32'h100, 32'd0, 1'b0, 1'b0);
    drive("beq_equal", 32'h1022_0003, 32'd9, 32'd9, 1'b0, 1'b0);
    drive("bne_differ", 32'h1422_0003, 32'd9, 32'd8, 1'b0, 1'b0);
    drive("and_sweep", rtype(6'h24), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("or_sweep", rtype(6'h25), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("xor_sweep", rtype(6'h26), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("nor_sweep", rtype(6'h27), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("sub_sweep", rtype(6'h22), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("slt_sweep", rtype(6'h2a), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("funct_zero", rtype(6'h00), 32'h8000_0000, 32'h1, 1'b0, 1'b0);
    drive("add_ovf", rtype(6'h20), 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drive("add_wrap", rtype(6'h20), 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    // rt_data equals sext(imm) so either reading of operand B gives the same sum.
    drive("unknown_op", 32'hFC22_FFF0, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b0);
    drive("flush_add", 32'h0022_1820, 32'd5, 32'd7, 1'b1, 1'b0);
    drive("after_flush", 32'h0022_1820, 32'd5, 32'd7, 1'b0, 1'b0);

    // The previous ADD shows up at this edge; rst between edges must clear it at once.
    drive("rst_midcycle", 32'h0022_1820, 32'd1, 32'd2, 1'b0, 1'b1);
    #1;
    check("rst_async_clear", '0);
    drive("rst_and_flush", 32'h0022_1820, 32'd1, 32'd2, 1'b1, 1'b1);
    drive("after_rst", 32'h0022_1820, 32'd1, 32'd2, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      i = $urandom;
      i[31:26] = ops[$urandom_range(7)];
      if (i[31:26] == 6'h00) i[5:0] = functs[$urandom_range(8)];
      a = ($urandom_range(3) == 0) ? 32'h8000_0000 >> $urandom_range(1) : $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      if (i[31:26] == 6'h3f) b = {{16{i[15]}}, i[15:0]};
      drive("random", i, a, b, ($urandom_range(19) == 0), ($urandom_range(49) == 0));
    end
    drive("drain", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    for (int k = 0; k < 10 && scoreboard.size() != 0; k++) @(posedge clk);
    #5;
    n_cmp++;
    if (scoreboard.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", scoreboard.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
